exp3_ker_ram_writer: RTL and testbench

EXP3_KER_RAM_WRITER -- requirements
Module: exp3_ker_ram_writer

---
 rtl/exp3_ker_ram_writer_pkg.sv | 22 ++
 rtl/exp3_ker_ram_writer_if.sv | 24 ++
 rtl/exp3_ker_ram_writer_bank_tracker.sv | 48 ++++
 rtl/exp3_ker_ram_writer.sv | 154 +++++++++++++++
 tb/tb_exp3_ker_ram_writer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exp3_ker_ram_writer_pkg.sv
// Shared 3x3-conv kernel-path definitions: write FSM states, bank geometry, address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exp_3x3_pkg;

    localparam int                ADDR_W     = 7;
    localparam logic [ADDR_W-1:0] BANK1_BASE = 7'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE,
        ST_BANK_WAIT,
        ST_DONE
    } wr_state_e;

    // Kernel RAM address of a beat: bank selects the 64-entry half, offset indexes within it.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [5:0] off);
        return (bank ? BANK1_BASE : ADDR_W'(0)) | {1'b0, off};
    endfunction

endpackage

// File: rtl/exp3_ker_ram_writer_if.sv
// Kernel-weight stream in, kernel RAM write port out.
// Latency: n/a (wires only).
// Backpressure: ker_ready_o gates the stream; the RAM port is never stalled.
// Signal names are from the writer's point of view: master = upstream/RAM side, slave = writer.
interface exp3_ker_ram_writer_if #(
    parameter int DATA_W = 32
) ();
    logic                             ker_valid_i;
    logic [DATA_W-1:0]                ker_data_i;
    logic                             ker_ready_o;
    logic                             ram_wr_en_o;
    logic [exp_3x3_pkg::ADDR_W-1:0]   ram_wr_addr_o;
    logic [DATA_W-1:0]                ram_wr_data_o;

    modport master (
        output ker_valid_i, ker_data_i,
        input  ker_ready_o, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o
    );

    modport slave (
        input  ker_valid_i, ker_data_i,
        output ker_ready_o, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o
    );
endinterface

// File: rtl/exp3_ker_ram_writer_bank_tracker.sv
// Two-bank occupancy tracker: a bank is set full when written out, cleared when the reader releases it.
// Latency: flags update one cycle after set_i / rd_done_i / clr_i.
// Backpressure: none; release pulses arriving with no full bank are dropped.
// Ports: clk_i, rst_i, clr_i (new layer), set_i + set_bank_i (bank completed),
//        rd_done_i (oldest bank released), bank_full_o[1:0].
module exp3_bank_tracker (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       set_i,
    input  logic       set_bank_i,
    input  logic       rd_done_i,
    output logic [1:0] bank_full_o
);
    logic [1:0] full_q, full_d;
    logic       rd_ptr_q, rd_ptr_d;

    always_comb begin
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            full_d   = 2'b00;
            rd_ptr_d = 1'b0;
        end else begin
            // Release is judged on the flags before this cycle's set, so a set of
            // one bank and a release of the other both land in the same cycle.
            if (rd_done_i && (full_q != 2'b00)) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
            end
            if (set_i) begin
                full_d[set_bank_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q   <= 2'b00;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign bank_full_o = full_q;
endmodule

// File: rtl/exp3_ker_ram_writer.sv
// Writes kernel-weight beats into a double-banked (2x64) kernel RAM, ping-ponging banks per chunk.
// Latency: accepted beat appears on the RAM write port 1 cycle later.
// Backpressure: ker_ready_o is registered and low while settling, waiting on a full bank, idle or done.
// Ports: clk_i/rst_i; start_i, wr_end_addr_i, fire_end_flag_i from the write-config block;
//        ker_if (stream in, RAM write out); rd_bank_done_i from the read side;
//        chk_nxt_addr_limt_o, bank_full_o, layer_done_o status.
module exp3_ker_ram_writer
    import exp_3x3_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     wr_end_addr_i,
    input  logic                  fire_end_flag_i,
    input  logic                  rd_bank_done_i,
    exp3_ker_ram_writer_if.slave  ker_if,
    output logic                  chk_nxt_addr_limt_o,
    output logic [1:0]            bank_full_o,
    output logic                  layer_done_o
);
    localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    wr_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic [5:0]        offset_q, offset_d;
    logic              ker_ready_q, ker_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              chk_q, chk_d;
    logic              layer_done_q, layer_done_d;
    logic              trk_clr;
    logic              beat_acc;
    logic [ADDR_W-1:0] beat_addr;

    // ker_ready_q is only ever high in WRITE, so it alone qualifies acceptance.
    assign beat_acc  = ker_if.ker_valid_i & ker_ready_q;
    assign beat_addr = bank_addr(wr_bank_q, offset_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_bank_d    = wr_bank_q;
        offset_d     = offset_q;
        layer_done_d = layer_done_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        chk_d        = 1'b0;
        trk_clr      = 1'b0;

        if (start_i) begin
            state_d      = ST_SETTLE;
            cnt_d        = CNT_W'(SETTLE_CYC);
            wr_bank_d    = 1'b0;
            offset_d     = 6'd0;
            layer_done_d = 1'b0;
            trk_clr      = 1'b1;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (fire_end_flag_i) begin
                        state_d      = ST_DONE;
                        layer_done_d = 1'b1;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        // Leave on the edge where the count reaches zero so ready is
                        // low for exactly SETTLE_CYC cycles.
                        cnt_d   = '0;
                        state_d = bank_full_o[wr_bank_q] ? ST_BANK_WAIT : ST_WRITE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (beat_acc) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = beat_addr;
                        wr_data_d = ker_if.ker_data_i;
                        offset_d  = offset_q + 6'd1;
                        // Full 7-bit compare: an end address in the other bank never hits.
                        if (beat_addr == wr_end_addr_i) begin
                            chk_d     = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            offset_d  = 6'd0;
                            state_d   = ST_SETTLE;
                            cnt_d     = CNT_W'(SETTLE_CYC);
                        end
                    end
                end
                ST_BANK_WAIT: begin
                    if (fire_end_flag_i) begin
                        state_d      = ST_DONE;
                        layer_done_d = 1'b1;
                    end else if (!bank_full_o[wr_bank_q]) begin
                        state_d = ST_WRITE;
                    end
                end
                default: begin
                end
            endcase
        end

        ker_ready_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_bank_q    <= 1'b0;
            offset_q     <= 6'd0;
            ker_ready_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            chk_q        <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_bank_q    <= wr_bank_d;
            offset_q     <= offset_d;
            ker_ready_q  <= ker_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            chk_q        <= chk_d;
            layer_done_q <= layer_done_d;
        end
    end

    // The bank is marked full together with the chk pulse, which lets a release of
    // the other bank in that same cycle resolve cleanly inside the tracker.
    exp3_bank_tracker u_bank_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (trk_clr),
        .set_i       (chk_q),
        .set_bank_i  (wr_addr_q[ADDR_W-1]),
        .rd_done_i   (rd_bank_done_i),
        .bank_full_o (bank_full_o)
    );

    assign ker_if.ker_ready_o   = ker_ready_q;
    assign ker_if.ram_wr_en_o   = wr_en_q;
    assign ker_if.ram_wr_addr_o = wr_addr_q;
    assign ker_if.ram_wr_data_o = wr_data_q;
    assign chk_nxt_addr_limt_o  = chk_q;
    assign layer_done_o         = layer_done_q;
endmodule

// File: tb/tb_exp3_ker_ram_writer.sv
// Directed bench for exp3_ker_ram_writer: reset, nominal ping-pong, backpressure, ignored
// release, offset wrap, layer end and mid-bank reset. Inputs change and outputs are
// sampled on the falling edge; the RTL acts on the rising edge.
module tb_exp3_ker_ram_writer;
    import exp_3x3_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [6:0] wr_end_addr_i;
    logic       fire_end_flag_i;
    logic       rd_bank_done_i;
    logic       chk_nxt_addr_limt_o;
    logic [1:0] bank_full_o;
    logic       layer_done_o;

    exp3_ker_ram_writer_if #(.DATA_W(32)) bus ();

    exp3_ker_ram_writer #(.DATA_W(32), .SETTLE_CYC(2)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start_i             (start_i),
        .wr_end_addr_i       (wr_end_addr_i),
        .fire_end_flag_i     (fire_end_flag_i),
        .rd_bank_done_i      (rd_bank_done_i),
        .ker_if              (bus.slave),
        .chk_nxt_addr_limt_o (chk_nxt_addr_limt_o),
        .bank_full_o         (bank_full_o),
        .layer_done_o        (layer_done_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int unsigned seq    = 0;
    logic [31:0] prev_data;

    // Advance to the next falling edge; prev_data is the beat that was on the bus
    // for the rising edge just passed, i.e. what a write seen now must carry.
    task automatic tick();
        logic [31:0] pd;
        pd = bus.ker_data_i;
        @(negedge clk_i);
        seq++;
        bus.ker_data_i = 32'hD000_0000 + seq;
        prev_data = pd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; wr_end_addr_i = 7'd0; fire_end_flag_i = 1'b0;
        rd_bank_done_i = 1'b0; bus.ker_valid_i = 1'b0; bus.ker_data_i = 32'd0;
        tick(); tick();
        checks++; if (bus.ker_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.ker_ready_o); end
        checks++; if (bus.ram_wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", bus.ram_wr_en_o); end
        checks++; if (bus.ram_wr_addr_o !== 7'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", bus.ram_wr_addr_o); end
        checks++; if (bus.ram_wr_data_o !== 32'd0) begin errors++; $display("FAIL rst_data got %h want 0", bus.ram_wr_data_o); end
        checks++; if (chk_nxt_addr_limt_o !== 1'b0) begin errors++; $display("FAIL rst_chk got %b want 0", chk_nxt_addr_limt_o); end
        checks++; if (bank_full_o !== 2'b00) begin errors++; $display("FAIL rst_bank_full got %b want 00", bank_full_o); end
        checks++; if (layer_done_o !== 1'b0) begin errors++; $display("FAIL rst_layer_done got %b want 0", layer_done_o); end
        rst_i = 1'b0;
        bus.ker_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (bus.ker_ready_o !== 1'b0 || bus.ram_wr_en_o !== 1'b0) begin
                errors++; $display("FAIL idle_no_write c=%0d got rdy=%b we=%b want 0 0", c, bus.ker_ready_o, bus.ram_wr_en_o);
            end
        end
    endtask

    // Two banks, release 10 cycles after each chk; the second release coincides with the
    // third chk pulse, so bank0 sets while bank1 clears in one cycle.
    task automatic test_nominal();
        logic       exp_rdy [26];
        int         exp_wa  [26];
        logic       exp_chk [26];
        logic [1:0] exp_bf  [26];
        logic       exp_we;
        exp_rdy = '{0,0,1,1,1,1,0,0,1,1,1,1,0,0,0,0,0,0,1,1,1,1,0,0,1,1};
        exp_wa  = '{-1,-1,-1,0,1,2,3,-1,-1,64,65,66,67,-1,-1,-1,-1,-1,-1,0,1,2,3,-1,-1,64};
        exp_chk = '{0,0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,1,0,0,0};
        exp_bf  = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,
                    2'b11,2'b11,2'b11,2'b11,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b01,2'b01,2'b01};
        bus.ker_valid_i = 1'b1;
        wr_end_addr_i = 7'd3;
        start_i = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            start_i = 1'b0;
            exp_we = (exp_wa[c-1] >= 0);
            checks++; if (bus.ker_ready_o !== exp_rdy[c-1]) begin errors++; $display("FAIL nom_ready c=%0d got %b want %b", c, bus.ker_ready_o, exp_rdy[c-1]); end
            checks++; if (bus.ram_wr_en_o !== exp_we) begin errors++; $display("FAIL nom_wr_en c=%0d got %b want %b", c, bus.ram_wr_en_o, exp_we); end
            if (exp_we) begin
                checks++; if (bus.ram_wr_addr_o !== 7'(exp_wa[c-1])) begin errors++; $display("FAIL nom_addr c=%0d got %0d want %0d", c, bus.ram_wr_addr_o, exp_wa[c-1]); end
                checks++; if (bus.ram_wr_data_o !== prev_data) begin errors++; $display("FAIL nom_data c=%0d got %h want %h", c, bus.ram_wr_data_o, prev_data); end
            end
            checks++; if (chk_nxt_addr_limt_o !== exp_chk[c-1]) begin errors++; $display("FAIL nom_chk c=%0d got %b want %b", c, chk_nxt_addr_limt_o, exp_chk[c-1]); end
            checks++; if (bank_full_o !== exp_bf[c-1]) begin errors++; $display("FAIL nom_bank_full c=%0d got %b want %b", c, bank_full_o, exp_bf[c-1]); end
            rd_bank_done_i = (c == 17 || c == 23);
            if (c == 7 || c == 23) wr_end_addr_i = 7'd67;
            if (c == 13) wr_end_addr_i = 7'd3;
        end
        rd_bank_done_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int chk_cnt = 0;
        bus.ker_valid_i = 1'b1;
        wr_end_addr_i = 7'd3;
        start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start_i = 1'b0;
            if (chk_nxt_addr_limt_o === 1'b1) chk_cnt++;
            if (c >= 14) begin
                checks++; if (bus.ker_ready_o !== 1'b0 || bus.ram_wr_en_o !== 1'b0) begin
                    errors++; $display("FAIL bp_stalled c=%0d got rdy=%b we=%b want 0 0", c, bus.ker_ready_o, bus.ram_wr_en_o);
                end
                checks++; if (bank_full_o !== 2'b11) begin errors++; $display("FAIL bp_bank_full c=%0d got %b want 11", c, bank_full_o); end
            end
            if (c == 7) wr_end_addr_i = 7'd67;
            if (c == 13) wr_end_addr_i = 7'd3;
        end
        checks++; if (chk_cnt != 2) begin errors++; $display("FAIL bp_chk_count got %0d want 2", chk_cnt); end
        rd_bank_done_i = 1'b1;
        tick();
        rd_bank_done_i = 1'b0;
        checks++; if (bank_full_o !== 2'b10) begin errors++; $display("FAIL bp_release got %b want 10", bank_full_o); end
        tick();
        checks++; if (bus.ker_ready_o !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %b want 1", bus.ker_ready_o); end
        tick();
        checks++; if (bus.ram_wr_en_o !== 1'b1 || bus.ram_wr_addr_o !== 7'd0) begin
            errors++; $display("FAIL bp_resume_write got we=%b addr=%0d want 1 0", bus.ram_wr_en_o, bus.ram_wr_addr_o);
        end
    endtask

    // First release arrives with both banks empty and must not move the read pointer,
    // so the later release clears bank0 rather than bank1.
    task automatic test_ignore_pulse();
        bus.ker_valid_i = 1'b1;
        wr_end_addr_i = 7'd3;
        start_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start_i = 1'b0;
            if (c == 2) begin
                checks++; if (bank_full_o !== 2'b00) begin errors++; $display("FAIL ign_empty got %b want 00", bank_full_o); end
            end
            if (c == 8) begin
                checks++; if (bank_full_o !== 2'b01) begin errors++; $display("FAIL ign_set got %b want 01", bank_full_o); end
            end
            if (c == 9) begin
                checks++; if (bank_full_o !== 2'b00) begin errors++; $display("FAIL ign_clear_bank0 got %b want 00", bank_full_o); end
            end
            rd_bank_done_i = (c == 1 || c == 8);
            if (c == 7) wr_end_addr_i = 7'd67;
        end
        rd_bank_done_i = 1'b0;
    endtask

    // End address in bank1 while writing bank0: offset wraps 63->0 with no chk.
    task automatic test_wrap();
        bus.ker_valid_i = 1'b1;
        wr_end_addr_i = 7'd67;
        start_i = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            tick();
            start_i = 1'b0;
            if (c >= 4) begin
                checks++; if (bus.ram_wr_en_o !== 1'b1 || bus.ram_wr_addr_o !== 7'((c - 4) % 64) || chk_nxt_addr_limt_o !== 1'b0) begin
                    errors++; $display("FAIL wrap c=%0d got we=%b addr=%0d chk=%b want 1 %0d 0",
                                       c, bus.ram_wr_en_o, bus.ram_wr_addr_o, chk_nxt_addr_limt_o, (c - 4) % 64);
                end
            end
        end
    endtask

    task automatic test_layer_end();
        bus.ker_valid_i = 1'b1;
        wr_end_addr_i = 7'd3;
        start_i = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start_i = 1'b0;
            if (c == 7) begin
                checks++; if (chk_nxt_addr_limt_o !== 1'b1) begin errors++; $display("FAIL end_final_chk got %b want 1", chk_nxt_addr_limt_o); end
            end
            if (c == 8) begin
                checks++; if (layer_done_o !== 1'b0) begin errors++; $display("FAIL end_not_yet got %b want 0", layer_done_o); end
            end
            if (c >= 9) begin
                checks++; if (layer_done_o !== 1'b1 || bus.ker_ready_o !== 1'b0 || bus.ram_wr_en_o !== 1'b0) begin
                    errors++; $display("FAIL end_done c=%0d got ld=%b rdy=%b we=%b want 1 0 0", c, layer_done_o, bus.ker_ready_o, bus.ram_wr_en_o);
                end
            end
            if (c == 7) wr_end_addr_i = 7'd67;
            fire_end_flag_i = (c == 8 || c == 9);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (layer_done_o !== 1'b0) begin errors++; $display("FAIL end_restart got %b want 0", layer_done_o); end
    endtask

    task automatic test_reset_mid();
        bus.ker_valid_i = 1'b1;
        wr_end_addr_i = 7'd3;
        start_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_i = 1'b0;
        end
        checks++; if (bus.ram_wr_en_o !== 1'b1 || bus.ram_wr_addr_o !== 7'd2) begin
            errors++; $display("FAIL mid_pre got we=%b addr=%0d want 1 2", bus.ram_wr_en_o, bus.ram_wr_addr_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (bus.ker_ready_o !== 1'b0 || bus.ram_wr_en_o !== 1'b0 || chk_nxt_addr_limt_o !== 1'b0 || layer_done_o !== 1'b0) begin
            errors++; $display("FAIL mid_async_ctrl got rdy=%b we=%b chk=%b ld=%b want 0 0 0 0",
                               bus.ker_ready_o, bus.ram_wr_en_o, chk_nxt_addr_limt_o, layer_done_o);
        end
        checks++; if (bus.ram_wr_addr_o !== 7'd0 || bus.ram_wr_data_o !== 32'd0 || bank_full_o !== 2'b00) begin
            errors++; $display("FAIL mid_async_data got addr=%0d data=%h bf=%b want 0 0 00",
                               bus.ram_wr_addr_o, bus.ram_wr_data_o, bank_full_o);
        end
        tick(); tick();
        rst_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++; if (bus.ram_wr_en_o !== 1'b0 || bus.ker_ready_o !== 1'b0) begin
                errors++; $display("FAIL mid_no_write c=%0d got we=%b rdy=%b want 0 0", c, bus.ram_wr_en_o, bus.ker_ready_o);
            end
        end
        start_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start_i = 1'b0;
        end
        checks++; if (bus.ram_wr_en_o !== 1'b1 || bus.ram_wr_addr_o !== 7'd0) begin
            errors++; $display("FAIL mid_restart got we=%b addr=%0d want 1 0", bus.ram_wr_en_o, bus.ram_wr_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_ignore_pulse();
        test_wrap();
        test_layer_end();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
